// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multicycle MIPS core: one shared ALU, unified req/ready memory port, fault state
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 0,
  parameter int          TO_W     = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic        retire,
  output logic        fault
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTEX,
    S_RTWB, S_IMMEX, S_IMMWB, S_BRANCH, S_JUMP, S_FAULT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_ADD = 6'h20, F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_SLL = 4'b1000, ALU_SRL = 4'b1001;

  // Timeout fires on the wait edge that would bring the count up to TIMEOUT
  localparam bit            TO_EN   = (TIMEOUT > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t          state;
  logic [31:0]     ir, a, b, alu_out, mdr;
  logic [31:0]     rf [32];
  logic [TO_W-1:0] to_cnt;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] sext_imm, zext_imm, rd_a, rd_b;
  logic [31:0] src_a, src_b, alu_y;
  logic [3:0]  alu_ctrl, rt_ctrl;
  logic        zero, waiting, rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  state_t      dispatch;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign shamt    = ir[10:6];
  assign funct    = ir[5:0];
  assign sext_imm = {{16{ir[15]}}, ir[15:0]};
  assign zext_imm = {16'h0000, ir[15:0]};
  assign rd_a     = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rd_b     = (rt == 5'd0) ? 32'd0 : rf[rt];

  // Moore outputs; reset gates the request so an in-flight access aborts immediately
  assign mem_req   = !reset && (state == S_FETCH || state == S_MEMRD || state == S_MEMWR);
  assign mem_we    = !reset && (state == S_MEMWR);
  assign mem_addr  = (state == S_FETCH) ? pc : alu_out;
  assign mem_wdata = b;
  assign fault     = (state == S_FAULT);
  assign retire    = (state == S_MEMWB) || (state == S_RTWB) || (state == S_IMMWB) ||
                     (state == S_BRANCH) || (state == S_JUMP) || (state == S_MEMWR && mem_ready);
  assign waiting   = mem_req && !mem_ready;

  assign rf_we = (state == S_MEMWB) || (state == S_RTWB) || (state == S_IMMWB);
  assign rf_wa = (state == S_RTWB) ? rd : rt;
  assign rf_wd = (state == S_MEMWB) ? mdr : alu_out;

  // Opcode/funct dispatch out of DECODE; anything unrecognised faults
  always_comb begin
    dispatch = S_FAULT;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL: dispatch = S_RTEX;
          default: dispatch = S_FAULT;
        endcase
      end
      OP_LW, OP_SW:    dispatch = S_MEMADR;
      OP_BEQ, OP_BNE:  dispatch = S_BRANCH;
      OP_ADDI, OP_ORI: dispatch = S_IMMEX;
      OP_J:            dispatch = S_JUMP;
      default:         dispatch = S_FAULT;
    endcase
  end

  // R-type funct to ALU control
  always_comb begin
    rt_ctrl = ALU_ADD;
    case (funct)
      F_SUB:   rt_ctrl = ALU_SUB;
      F_AND:   rt_ctrl = ALU_AND;
      F_OR:    rt_ctrl = ALU_OR;
      F_SLT:   rt_ctrl = ALU_SLT;
      F_SLL:   rt_ctrl = ALU_SLL;
      F_SRL:   rt_ctrl = ALU_SRL;
      default: rt_ctrl = ALU_ADD;
    endcase
  end

  // Operand selection for the single shared ALU, by state
  always_comb begin
    src_a    = a;
    src_b    = b;
    alu_ctrl = ALU_ADD;
    case (state)
      S_FETCH: begin
        src_a = pc;
        src_b = 32'd4;
      end
      S_DECODE: begin
        src_a = pc;
        src_b = {sext_imm[29:0], 2'b00};
      end
      S_MEMADR: src_b = sext_imm;
      S_RTEX:   alu_ctrl = rt_ctrl;
      S_IMMEX: begin
        src_b    = (opcode == OP_ORI) ? zext_imm : sext_imm;
        alu_ctrl = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_BRANCH: alu_ctrl = ALU_SUB;
      default: ;
    endcase
  end

  // The ALU itself; shifts act on the rt operand by shamt
  always_comb begin
    alu_y = 32'd0;
    case (alu_ctrl)
      ALU_AND: alu_y = src_a & src_b;
      ALU_OR:  alu_y = src_a | src_b;
      ALU_ADD: alu_y = src_a + src_b;
      ALU_SUB: alu_y = src_a - src_b;
      ALU_SLT: alu_y = {31'd0, $signed(src_a) < $signed(src_b)};
      ALU_SLL: alu_y = src_b << shamt;
      ALU_SRL: alu_y = src_b >> shamt;
      default: alu_y = 32'd0;
    endcase
  end

  assign zero = (alu_y == 32'd0);

  // Register file write port; register 0 is never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (rf_we && rf_wa != 5'd0) begin
      rf[rf_wa] <= rf_wd;
    end
  end

  // Control FSM with datapath registers and the memory wait timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= 32'd0;
      a       <= 32'd0;
      b       <= 32'd0;
      alu_out <= 32'd0;
      mdr     <= 32'd0;
      to_cnt  <= '0;
    end else if (TO_EN && waiting && to_cnt == TO_LAST) begin
      state  <= S_FAULT;
      to_cnt <= '0;
    end else begin
      to_cnt <= waiting ? to_cnt + 1'b1 : '0;
      case (state)
        S_FETCH: if (mem_ready) begin
          ir    <= mem_rdata;
          pc    <= alu_y;
          state <= S_DECODE;
        end
        S_DECODE: begin
          a       <= rd_a;
          b       <= rd_b;
          alu_out <= alu_y;
          state   <= dispatch;
        end
        S_MEMADR: begin
          alu_out <= alu_y;
          state   <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: if (mem_ready) begin
          mdr   <= mem_rdata;
          state <= S_MEMWB;
        end
        S_MEMWR: if (mem_ready) state <= S_FETCH;
        S_RTEX: begin
          alu_out <= alu_y;
          state   <= S_RTWB;
        end
        S_IMMEX: begin
          alu_out <= alu_y;
          state   <= S_IMMWB;
        end
        S_MEMWB, S_RTWB, S_IMMWB: state <= S_FETCH;
        S_BRANCH: begin
          if ((opcode == OP_BEQ) ? zero : !zero) pc <= alu_out;
          state <= S_FETCH;
        end
        S_JUMP: begin
          pc    <= {pc[31:28], ir[25:0], 2'b00};
          state <= S_FETCH;
        end
        S_FAULT: state <= S_FAULT;
        default: state <= S_FAULT;
      endcase
    end
  end

endmodule
